fifo_burst_reader: RTL

- Read-side drain engine for the team's synchronous FIFO. Sits between the FIFO read port and a downstream valid/ready stream consumer.
- Monitors FIFO occupancy and pops entries in bursts of BURST_LEN beats. Presents each beat on a registered valid/ready output with a last-beat marker.
- Issues a partial burst on a timeout or on an explicit flush request, so residual data never strands.

---
 rtl/fifo_burst_reader_if.sv | 9 +
 rtl/fifo_burst_reader.sv | 82 ++++++++
 2 files changed

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: valid/ready beat stream with a last-beat marker
interface fifo_burst_reader_if #(parameter int DATA_WIDTH = 8);
   logic                  valid;
   logic                  ready;
   logic                  last;
   logic [DATA_WIDTH-1:0] data;
   modport master(output valid, data, last, input ready);
   modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a sync FIFO in BURST_LEN bursts onto a valid/ready stream, partial bursts on timeout/flush
// Optional burst counters under FIFO_BURST_READER_STATS_EN
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int BURST_LEN  = 4,
   parameter int TIMEOUT    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [ADDR_WIDTH:0]   fifo_count,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   fifo_burst_reader_if.master   m,
`ifdef FIFO_BURST_READER_STATS_EN
   output logic [15:0]           stat_full_bursts,
   output logic [15:0]           stat_partial_bursts,
`endif
   output logic                  busy
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] BL = CW'(BURST_LEN);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, BURST, WAIT_LAST} state_t;
   state_t        state;
   logic [CW-1:0] beat_cnt, burst_len;
   logic [TW-1:0] timer;
   logic          full, go, accept, lastbeat;
   always_comb begin
      full = fifo_count >= BL;
      go = full || (fifo_count != '0 && (flush || timer == TLAST));
      accept = m.valid && m.ready;
      lastbeat = beat_cnt == burst_len - CW'(1);
      fifo_rd_en = state == BURST && !fifo_empty && (!m.valid || m.ready);
      busy = state != IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         m.valid   <= 1'b0;
         m.data    <= '0;
         m.last    <= 1'b0;
         beat_cnt  <= '0;
         burst_len <= '0;
         timer     <= '0;
`ifdef FIFO_BURST_READER_STATS_EN
         stat_full_bursts    <= '0;
         stat_partial_bursts <= '0;
`endif
      end else begin
         if (state == IDLE) begin
            timer <= (fifo_count == '0 || go) ? '0 : (timer == TLAST ? timer : timer + 1'b1);
            if (go) begin
               burst_len <= full ? BL : fifo_count;
               state     <= BURST;
            end
         end
         if (fifo_rd_en) begin
            m.data   <= fifo_rd_data;
            m.valid  <= 1'b1;
            m.last   <= lastbeat;
            beat_cnt <= lastbeat ? '0 : beat_cnt + 1'b1;
            if (lastbeat) state <= WAIT_LAST;
         end else if (accept) begin
            m.valid <= 1'b0;
            m.last  <= 1'b0;
            if (state == WAIT_LAST) begin
               state <= IDLE;
`ifdef FIFO_BURST_READER_STATS_EN
               // burst_len below BURST_LEN only arises from timeout or flush entry
               if (burst_len == BL) stat_full_bursts <= stat_full_bursts + 16'd1;
               else stat_partial_bursts <= stat_partial_bursts + 16'd1;
`endif
            end
         end
      end
   end
endmodule
